// File: rtl/color_track_hist_pkg.sv
// rtl/color_track_hist_pkg.sv - shared FSM states, filter bit positions and zone helper
package color_track_hist_pkg;

    typedef enum logic [2:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_ACCUM,
        ST_DRAIN,
        ST_SCAN,
        ST_UPDATE
    } state_e;

    localparam int FLT_R = 2;
    localparam int FLT_G = 1;
    localparam int FLT_B = 0;

    // z = (col*n_zones)/cols as a chain of constant-bound compares.
    function automatic int zone_of(input int col, input int n_zones, input int cols);
        int z;
        z = 0;
        for (int i = 1; i < n_zones; i++) begin
            if (col * n_zones >= i * cols) z = i;
        end
        return z;
    endfunction

endpackage

// File: rtl/color_track_hist_color_match.sv
// rtl/color_track_hist_color_match.sv - per-channel threshold match over enabled channels
module color_match
    import color_track_hist_pkg::*;
#(
    parameter int C_NB_CH = 4
) (
    input  logic [3*C_NB_CH-1:0] pxl_i,
    input  logic [2:0]           rgbfilter_i,
    input  logic [C_NB_CH-1:0]   thr_r_i,
    input  logic [C_NB_CH-1:0]   thr_g_i,
    input  logic [C_NB_CH-1:0]   thr_b_i,
    output logic                 match_o
);

    logic [C_NB_CH-1:0] r, g, b;

    assign r = pxl_i[3*C_NB_CH-1 -: C_NB_CH];
    assign g = pxl_i[2*C_NB_CH-1 -: C_NB_CH];
    assign b = pxl_i[C_NB_CH-1:0];

    // An empty filter must never match, otherwise the AND below would be vacuously true.
    assign match_o = (rgbfilter_i != 3'b000)
                   && (!rgbfilter_i[FLT_R] || (r >= thr_r_i))
                   && (!rgbfilter_i[FLT_G] || (g >= thr_g_i))
                   && (!rgbfilter_i[FLT_B] || (b >= thr_b_i));

endmodule

// File: rtl/color_track_hist.sv
// rtl/color_track_hist.sv - frame colour tracker: column histogram, arg-max scan, zone output
module color_track_hist
    import color_track_hist_pkg::*;
#(
    parameter int C_IMG_COLS    = 80,
    parameter int C_IMG_ROWS    = 60,
    parameter int C_NB_IMG_PXLS = 13,
    parameter int C_NB_COL      = 7,
    parameter int C_NB_HIST     = 6,
    parameter int C_NB_CH       = 4,
    parameter int N_ZONES       = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic [2:0]               rgbfilter,
    input  logic [C_NB_CH-1:0]       thr_r,
    input  logic [C_NB_CH-1:0]       thr_g,
    input  logic [C_NB_CH-1:0]       thr_b,
    input  logic [C_NB_HIST-1:0]     min_cnt,
    input  logic [3*C_NB_CH-1:0]     orig_pxl,
    output logic [C_NB_IMG_PXLS-1:0] orig_addr,
    output logic                     proc_we,
    output logic [3*C_NB_CH-1:0]     proc_pxl,
    output logic [C_NB_IMG_PXLS-1:0] proc_addr,
    output logic [C_NB_COL-1:0]      col_out,
    output logic [C_NB_HIST-1:0]     peak_cnt,
    output logic                     target_found,
    output logic [N_ZONES-1:0]       zone_leds,
    output logic                     frame_done
);

    localparam int                     P         = C_IMG_COLS * C_IMG_ROWS;
    localparam logic [C_NB_IMG_PXLS-1:0] LAST_ADDR = C_NB_IMG_PXLS'(P - 1);
    localparam logic [C_NB_COL-1:0]    LAST_COL  = C_NB_COL'(C_IMG_COLS - 1);
    localparam logic [C_NB_HIST-1:0]   HIST_MAX  = '1;

    state_e                   state_q, state_d;
    logic [C_NB_IMG_PXLS-1:0] addr_q, addr_d, paddr_q;
    logic [C_NB_COL-1:0]      col_q, col_d, dcol_q, maxcol_q, maxcol_d;
    logic [C_NB_HIST-1:0]     max_q, max_d;
    logic [C_NB_HIST-1:0]     hist_q [C_IMG_COLS];
    logic                     vld_q, load_cfg;
    logic [2:0]               flt_q;
    logic [C_NB_CH-1:0]       thr_r_q, thr_g_q, thr_b_q;
    logic [C_NB_HIST-1:0]     min_q;
    logic [C_NB_COL-1:0]      col_out_q;
    logic [C_NB_HIST-1:0]     peak_q;
    logic                     found_q, done_q, match, hit, found;
    logic [N_ZONES-1:0]       leds_q, leds_d;
    logic [C_NB_COL-1:0]      rd_idx;
    logic [C_NB_HIST-1:0]     rd_val;

    color_match #(.C_NB_CH(C_NB_CH)) u_match (
        .pxl_i       (orig_pxl),
        .rgbfilter_i (flt_q),
        .thr_r_i     (thr_r_q),
        .thr_g_i     (thr_g_q),
        .thr_b_i     (thr_b_q),
        .match_o     (match)
    );

    // Single read port: SCAN walks col_q, otherwise it follows the delayed pixel column.
    assign rd_idx = (state_q == ST_SCAN) ? col_q : dcol_q;
    assign rd_val = hist_q[rd_idx];
    assign hit    = vld_q && match;
    assign found  = (max_q != '0) && (max_q >= min_q);

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        col_d    = col_q;
        max_d    = max_q;
        maxcol_d = maxcol_q;
        load_cfg = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                col_d = col_q + 1'b1;
                if (col_q == LAST_COL) begin
                    col_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (en) begin
                    state_d  = ST_ACCUM;
                    load_cfg = 1'b1;
                    addr_d   = '0;
                    col_d    = '0;
                end
            end
            ST_ACCUM: begin
                addr_d = addr_q + 1'b1;
                col_d  = (col_q == LAST_COL) ? '0 : col_q + 1'b1;
                if (addr_q == LAST_ADDR) begin
                    addr_d  = '0;
                    col_d   = '0;
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                state_d  = ST_SCAN;
                col_d    = '0;
                max_d    = '0;
                maxcol_d = '0;
            end
            ST_SCAN: begin
                if (rd_val > max_q) begin
                    max_d    = rd_val;
                    maxcol_d = col_q;
                end
                col_d = col_q + 1'b1;
                if (col_q == LAST_COL) begin
                    col_d   = '0;
                    state_d = ST_UPDATE;
                end
            end
            ST_UPDATE: begin
                if (en) begin
                    state_d  = ST_ACCUM;
                    load_cfg = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_CLEAR;
        endcase
    end

    always_comb begin
        leds_d = '0;
        if (found) leds_d = N_ZONES'(1) << (N_ZONES - 1 - zone_of(int'(maxcol_q), N_ZONES, C_IMG_COLS));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_CLEAR;
            addr_q    <= '0;
            col_q     <= '0;
            dcol_q    <= '0;
            paddr_q   <= '0;
            vld_q     <= 1'b0;
            max_q     <= '0;
            maxcol_q  <= '0;
            flt_q     <= '0;
            thr_r_q   <= '0;
            thr_g_q   <= '0;
            thr_b_q   <= '0;
            min_q     <= '0;
            col_out_q <= '0;
            peak_q    <= '0;
            found_q   <= 1'b0;
            leds_q    <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            col_q    <= col_d;
            dcol_q   <= col_q;
            paddr_q  <= addr_q;
            vld_q    <= (state_q == ST_ACCUM);
            max_q    <= max_d;
            maxcol_q <= maxcol_d;
            done_q   <= (state_q == ST_UPDATE);
            if (load_cfg) begin
                flt_q   <= rgbfilter;
                thr_r_q <= thr_r;
                thr_g_q <= thr_g;
                thr_b_q <= thr_b;
                min_q   <= min_cnt;
            end
            if (state_q == ST_UPDATE) begin
                col_out_q <= found ? maxcol_q : '0;
                peak_q    <= max_q;
                found_q   <= found;
                leds_q    <= leds_d;
            end
        end
    end

    // CLEAR and SCAN both zero the bin they visit, so every frame starts from an empty histogram.
    always_ff @(posedge clk) begin
        if (state_q == ST_CLEAR || state_q == ST_SCAN) begin
            hist_q[col_q] <= '0;
        end else if (hit && rd_val != HIST_MAX) begin
            hist_q[dcol_q] <= rd_val + 1'b1;
        end
    end

    assign orig_addr    = addr_q;
    assign proc_we      = vld_q;
    assign proc_addr    = paddr_q;
    assign proc_pxl     = (vld_q && (match || flt_q == 3'b000)) ? orig_pxl : '0;
    assign col_out      = col_out_q;
    assign peak_cnt     = peak_q;
    assign target_found = found_q;
    assign zone_leds    = leds_q;
    assign frame_done   = done_q;

endmodule

// File: tb/tb_color_track_hist.sv
// tb/tb_color_track_hist.sv - self-checking bench for color_track_hist
module tb_color_track_hist;

    localparam int COLS = 80;
    localparam int ROWS = 60;
    localparam int P    = COLS * ROWS;
    localparam int NZ   = 8;

    logic        clk = 1'b0;
    logic        rst_n, en;
    logic [2:0]  rgbfilter;
    logic [3:0]  thr_r, thr_g, thr_b;
    logic [5:0]  min_cnt;
    logic [11:0] orig_pxl;

    logic [12:0] orig_addr, proc_addr;
    logic        proc_we, target_found, frame_done;
    logic [11:0] proc_pxl;
    logic [6:0]  col_out;
    logic [5:0]  peak_cnt;
    logic [7:0]  zone_leds;

    logic [12:0] orig_addr5, proc_addr5;
    logic        proc_we5, target_found5, frame_done5;
    logic [11:0] proc_pxl5;
    logic [6:0]  col_out5;
    logic [4:0]  peak_cnt5;
    logic [7:0]  zone_leds5;

    logic [11:0] mem [P];
    logic [12:0] prev_addr = '0;

    int n_chk  = 0;
    int n_pass = 0;
    int exp_col6, exp_peak6, exp_leds, exp_col5, exp_peak5;
    bit exp_found6, exp_found5;

    always #5 clk = ~clk;

    color_track_hist dut (
        .clk(clk), .rst_n(rst_n), .en(en), .rgbfilter(rgbfilter),
        .thr_r(thr_r), .thr_g(thr_g), .thr_b(thr_b), .min_cnt(min_cnt),
        .orig_pxl(orig_pxl), .orig_addr(orig_addr), .proc_we(proc_we),
        .proc_pxl(proc_pxl), .proc_addr(proc_addr), .col_out(col_out),
        .peak_cnt(peak_cnt), .target_found(target_found),
        .zone_leds(zone_leds), .frame_done(frame_done)
    );

    color_track_hist #(.C_NB_HIST(5)) dut5 (
        .clk(clk), .rst_n(rst_n), .en(en), .rgbfilter(rgbfilter),
        .thr_r(thr_r), .thr_g(thr_g), .thr_b(thr_b), .min_cnt(min_cnt[4:0]),
        .orig_pxl(orig_pxl), .orig_addr(orig_addr5), .proc_we(proc_we5),
        .proc_pxl(proc_pxl5), .proc_addr(proc_addr5), .col_out(col_out5),
        .peak_cnt(peak_cnt5), .target_found(target_found5),
        .zone_leds(zone_leds5), .frame_done(frame_done5)
    );

    always @(posedge clk) orig_pxl <= (orig_addr < 13'(P)) ? mem[orig_addr] : 12'h000;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic bit tb_match(input logic [11:0] p);
        if (rgbfilter == 3'b000) return 1'b0;
        return (!rgbfilter[2] || p[11:8] >= thr_r) &&
               (!rgbfilter[1] || p[7:4]  >= thr_g) &&
               (!rgbfilter[0] || p[3:0]  >= thr_b);
    endfunction

    // Processed pixel and write address checked on every written pixel.
    always @(negedge clk) begin
        if (rst_n && proc_we) begin
            chk("proc_addr", 32'(proc_addr), 32'(prev_addr));
            chk("proc_pxl", 32'(proc_pxl),
                (rgbfilter == 3'b000 || tb_match(mem[prev_addr])) ? 32'(mem[prev_addr]) : 32'd0);
        end
        prev_addr <= orig_addr;
    end

    task automatic model();
        int cnt [COLS];
        int v;
        for (int c = 0; c < COLS; c++) cnt[c] = 0;
        for (int i = 0; i < P; i++) if (tb_match(mem[i])) cnt[i % COLS]++;
        exp_peak6 = 0; exp_col6 = 0; exp_peak5 = 0; exp_col5 = 0;
        for (int c = 0; c < COLS; c++) begin
            v = (cnt[c] > 63) ? 63 : cnt[c];
            if (v > exp_peak6) begin exp_peak6 = v; exp_col6 = c; end
            v = (cnt[c] > 31) ? 31 : cnt[c];
            if (v > exp_peak5) begin exp_peak5 = v; exp_col5 = c; end
        end
        exp_found6 = (exp_peak6 != 0) && (exp_peak6 >= int'(min_cnt));
        exp_found5 = (exp_peak5 != 0) && (exp_peak5 >= int'(min_cnt[4:0]));
        if (!exp_found6) exp_col6 = 0;
        if (!exp_found5) exp_col5 = 0;
        exp_leds = exp_found6 ? (1 << (NZ - 1 - (exp_col6 * NZ) / COLS)) : 0;
    endtask

    task automatic check_outputs(input string tag);
        model();
        chk({tag, "_col"}, 32'(col_out), 32'(exp_col6));
        chk({tag, "_found"}, 32'(target_found), 32'(exp_found6));
        chk({tag, "_leds"}, 32'(zone_leds), 32'(exp_leds));
        if (exp_found6) chk({tag, "_peak"}, 32'(peak_cnt), 32'(exp_peak6));
        chk({tag, "_col5"}, 32'(col_out5), 32'(exp_col5));
        chk({tag, "_found5"}, 32'(target_found5), 32'(exp_found5));
        if (exp_found5) chk({tag, "_peak5"}, 32'(peak_cnt5), 32'(exp_peak5));
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
        end while (!frame_done && cyc < 6000);
        if (!frame_done) chk("done_timeout", 32'(frame_done), 32'd1);
    endtask

    task automatic run_frame(input string tag);
        int c;
        en = 1'b1;
        repeat (3) @(posedge clk);
        #1 en = 1'b0;
        wait_done(c);
        check_outputs(tag);
    endtask

    task automatic fill_noise(input logic [11:0] mask);
        for (int i = 0; i < P; i++) mem[i] = 12'($urandom) & mask;
    endtask

    initial begin
        int c, seen_we, seen_done;
        rst_n = 1'b0; en = 1'b0; rgbfilter = 3'b000;
        thr_r = '0; thr_g = '0; thr_b = '0; min_cnt = '0;
        for (int i = 0; i < P; i++) mem[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_addr", 32'(orig_addr), 0);
        chk("rst_we", 32'(proc_we), 0);
        chk("rst_leds", 32'(zone_leds), 0);
        #1 rst_n = 1'b1;
        repeat (90) @(posedge clk);

        // Red bar in column 45, two back-to-back frames, en dropped during the second.
        fill_noise(12'h7FF);
        for (int r = 0; r < ROWS; r++) mem[r * COLS + 45] = 12'hF00;
        rgbfilter = 3'b100; thr_r = 4'd8; thr_g = 4'($urandom); thr_b = 4'($urandom); min_cnt = 6'd1;
        #1 en = 1'b1;
        wait_done(c);
        check_outputs("red1");
        chk("red_leds_const", 32'(zone_leds), 32'h08);
        chk("red_peak5_sat", 32'(peak_cnt5), 32'd31);
        en = 1'b0;
        wait_done(c);
        chk("period", c, 4882);
        check_outputs("red2");

        seen_we = 0; seen_done = 0;
        for (int i = 0; i < 5000; i++) begin
            @(posedge clk); #1;
            if (proc_we) seen_we++;
            if (frame_done) seen_done++;
        end
        chk("idle_we", seen_we, 0);
        chk("idle_done", seen_done, 0);
        chk("idle_addr", 32'(orig_addr), 0);

        // Reset mid-ACCUM: outputs clear immediately, CLEAR+IDLE precede the first write.
        en = 1'b1;
        repeat (500) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_addr", 32'(orig_addr), 0);
        chk("mid_rst_we", 32'(proc_we), 0);
        chk("mid_rst_pxl", 32'(proc_pxl), 0);
        chk("mid_rst_paddr", 32'(proc_addr), 0);
        chk("mid_rst_col", 32'(col_out), 0);
        chk("mid_rst_peak", 32'(peak_cnt), 0);
        chk("mid_rst_found", 32'(target_found), 0);
        chk("mid_rst_leds", 32'(zone_leds), 0);
        chk("mid_rst_done", 32'(frame_done), 0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        c = 0;
        do begin
            @(posedge clk); #1;
            c++;
        end while (!proc_we && c < 200);
        chk("clear_latency", c, 82);
        en = 1'b0;
        wait_done(c);
        check_outputs("after_rst");

        // Tie between columns 12 and 70; column 40 one short.
        for (int i = 0; i < P; i++) mem[i] = 12'($urandom) & 12'hF0F;
        for (int i = 0; i < P; i++) if ($urandom_range(1) == 1) mem[i][7:4] = 4'($urandom_range(8));
        for (int r = 0; r < 20; r++) begin
            mem[r * COLS + 12] = 12'h0F0;
            mem[r * COLS + 70] = 12'h0F0;
            if (r < 19) mem[r * COLS + 40] = 12'h0F0;
        end
        rgbfilter = 3'b010; thr_g = 4'd9; min_cnt = 6'd1;
        run_frame("tie");
        chk("tie_col_const", 32'(col_out), 32'd12);

        // Gate: three hits in column 79.
        fill_noise(12'hFFE);
        for (int r = 0; r < 3; r++) mem[(10 + r) * COLS + 79] = 12'h00F;
        rgbfilter = 3'b001; thr_b = 4'd15; min_cnt = 6'd4;
        run_frame("gate4");
        min_cnt = 6'd3;
        run_frame("gate3");
        chk("gate3_leds_const", 32'(zone_leds), 32'h01);

        // Empty filter: pass-through pixels, nothing counted.
        fill_noise(12'hFFF);
        rgbfilter = 3'b000; min_cnt = 6'd0;
        run_frame("nofilt");

        for (int f = 0; f < 4; f++) begin
            fill_noise(12'hFFF);
            rgbfilter = 3'($urandom_range(7, 1));
            thr_r = 4'($urandom); thr_g = 4'($urandom); thr_b = 4'($urandom);
            min_cnt = 6'($urandom_range(31));
            run_frame($sformatf("rand%0d", f));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
